// File: rtl/bolme_denetleyici.sv
// bolme_denetleyici: issue/retire controller in front of bolme_birimi.
// Optional one-entry result cache: define BOLME_ONBELLEK_EN.
`ifndef BOLME_DIV
`define BOLME_DIV  2'd0
`define BOLME_DIVU 2'd1
`define BOLME_REM  2'd2
`define BOLME_REMU 2'd3
`endif

module bolme_denetleyici #(
  parameter int VERI_GENISLIGI  = 32,
  parameter int HEDEF_GENISLIGI = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       istek_gecerli_i,
  output logic                       istek_hazir_o,
  input  logic [1:0]                 istek_islem_i,
  input  logic [VERI_GENISLIGI-1:0]  istek_bolunen_i,
  input  logic [VERI_GENISLIGI-1:0]  istek_bolen_i,
  input  logic [HEDEF_GENISLIGI-1:0] istek_hedef_i,
  input  logic                       iptal_i,
  output logic                       sonuc_gecerli_o,
  input  logic                       sonuc_hazir_i,
  output logic [VERI_GENISLIGI-1:0]  sonuc_o,
  output logic [HEDEF_GENISLIGI-1:0] sonuc_hedef_o,
  output logic                       bolme_baslat_o,
  output logic [1:0]                 bolme_islem_o,
  output logic [VERI_GENISLIGI-1:0]  bolme_bolunen_o,
  output logic [VERI_GENISLIGI-1:0]  bolme_bolen_o,
  input  logic [VERI_GENISLIGI-1:0]  bolme_sonuc_i,
  input  logic                       bolme_bitti_i,
  output logic [31:0]                mesgul_sayac_o
);

  typedef enum logic [1:0] {
    BOSTA,
    HESAPLA,
    SONUC
  } durum_t;

  durum_t                     durum_q, durum_d;
  logic                       baslat_q, baslat_d;
  logic [1:0]                 islem_q, islem_d;
  logic [VERI_GENISLIGI-1:0]  bolunen_q, bolunen_d;
  logic [VERI_GENISLIGI-1:0]  bolen_q, bolen_d;
  logic [VERI_GENISLIGI-1:0]  sonuc_q, sonuc_d;
  logic [HEDEF_GENISLIGI-1:0] hedef_q, hedef_d;
  logic [31:0]                sayac_q;
  logic                       kabul;
  logic                       bitti;

`ifdef BOLME_ONBELLEK_EN
  logic                      onb_gecerli_q, onb_gecerli_d;
  logic [1:0]                onb_islem_q, onb_islem_d;
  logic [VERI_GENISLIGI-1:0] onb_bolunen_q, onb_bolunen_d;
  logic [VERI_GENISLIGI-1:0] onb_bolen_q, onb_bolen_d;
  logic [VERI_GENISLIGI-1:0] onb_sonuc_q, onb_sonuc_d;
  logic                      onb_isabet;

  assign onb_isabet = onb_gecerli_q
                    && (onb_islem_q == istek_islem_i)
                    && (onb_bolunen_q == istek_bolunen_i)
                    && (onb_bolen_q == istek_bolen_i);
`endif

  // bitti is high while start is low, so only trust it with start held
  assign bitti = bolme_bitti_i && baslat_q;

  // Ready is forced low during reset so every output reads 0
  assign istek_hazir_o = rst_ni && ((durum_q == BOSTA)
                      || ((durum_q == SONUC) && sonuc_hazir_i && !iptal_i));
  assign kabul = istek_hazir_o && istek_gecerli_i && !iptal_i;

  // Next state: flush first, then completion/handshake, then a new accept
  always_comb begin
    durum_d   = durum_q;
    baslat_d  = baslat_q;
    islem_d   = islem_q;
    bolunen_d = bolunen_q;
    bolen_d   = bolen_q;
    sonuc_d   = sonuc_q;
    hedef_d   = hedef_q;
`ifdef BOLME_ONBELLEK_EN
    onb_gecerli_d = onb_gecerli_q;
    onb_islem_d   = onb_islem_q;
    onb_bolunen_d = onb_bolunen_q;
    onb_bolen_d   = onb_bolen_q;
    onb_sonuc_d   = onb_sonuc_q;
`endif
    unique case (durum_q)
      BOSTA: ;
      HESAPLA: begin
        if (iptal_i) begin
          baslat_d = 1'b0;
          durum_d  = BOSTA;
        end else if (bitti) begin
          sonuc_d  = bolme_sonuc_i;
          baslat_d = 1'b0;
          durum_d  = SONUC;
`ifdef BOLME_ONBELLEK_EN
          onb_gecerli_d = 1'b1;
          onb_islem_d   = islem_q;
          onb_bolunen_d = bolunen_q;
          onb_bolen_d   = bolen_q;
          onb_sonuc_d   = bolme_sonuc_i;
`endif
        end
      end
      SONUC: begin
        if (iptal_i || sonuc_hazir_i) durum_d = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
    if (kabul) begin
      islem_d   = istek_islem_i;
      bolunen_d = istek_bolunen_i;
      bolen_d   = istek_bolen_i;
      hedef_d   = istek_hedef_i;
      baslat_d  = 1'b1;
      durum_d   = HESAPLA;
`ifdef BOLME_ONBELLEK_EN
      if (onb_isabet) begin
        sonuc_d  = onb_sonuc_q;
        baslat_d = 1'b0;
        durum_d  = SONUC;
      end
`endif
    end
  end

  // State, operand and result registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum_q   <= BOSTA;
      baslat_q  <= 1'b0;
      islem_q   <= '0;
      bolunen_q <= '0;
      bolen_q   <= '0;
      sonuc_q   <= '0;
      hedef_q   <= '0;
    end else begin
      durum_q   <= durum_d;
      baslat_q  <= baslat_d;
      islem_q   <= islem_d;
      bolunen_q <= bolunen_d;
      bolen_q   <= bolen_d;
      sonuc_q   <= sonuc_d;
      hedef_q   <= hedef_d;
    end
  end

`ifdef BOLME_ONBELLEK_EN
  // Cache entry, invalidated only by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      onb_gecerli_q <= 1'b0;
      onb_islem_q   <= '0;
      onb_bolunen_q <= '0;
      onb_bolen_q   <= '0;
      onb_sonuc_q   <= '0;
    end else begin
      onb_gecerli_q <= onb_gecerli_d;
      onb_islem_q   <= onb_islem_d;
      onb_bolunen_q <= onb_bolunen_d;
      onb_bolen_q   <= onb_bolen_d;
      onb_sonuc_q   <= onb_sonuc_d;
    end
  end
`endif

  // Busy-cycle counter, wraps naturally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sayac_q <= '0;
    end else if (durum_q == HESAPLA) begin
      sayac_q <= sayac_q + 32'd1;
    end
  end

  assign sonuc_gecerli_o = (durum_q == SONUC);
  assign sonuc_o         = sonuc_q;
  assign sonuc_hedef_o   = hedef_q;
  assign bolme_baslat_o  = baslat_q;
  assign bolme_islem_o   = islem_q;
  assign bolme_bolunen_o = bolunen_q;
  assign bolme_bolen_o   = bolen_q;
  assign mesgul_sayac_o  = sayac_q;

endmodule

// File: tb/tb_bolme_denetleyici.sv
// tb_bolme_denetleyici: directed bench with a behavioural divider.
// Scoreboard queue holds expected {tag, result} per accepted request.
module tb_bolme_denetleyici;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;
  // start high for 19 cycles before bitti; result visible after the
  // 19th edge past accept (20th edge counting the accept edge)
  localparam int DIV_LAT = 19;
  localparam int EXP_LAT = 19;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] val;
  } bek_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ig = 1'b0;
  logic        ih;
  logic [1:0]  iop = '0;
  logic [31:0] ia = '0;
  logic [31:0] ib = '0;
  logic [4:0]  itag = '0;
  logic        iptal = 1'b0;
  logic        sg;
  logic        sh = 1'b0;
  logic [31:0] sonuc;
  logic [4:0]  stag;
  logic        baslat;
  logic [1:0]  bop;
  logic [31:0] ba, bb;
  logic [31:0] bsonuc;
  logic        bbitti;
  logic [31:0] sayac;

  int tests = 0;
  int fails = 0;
  bek_t sb[$];

  always #5 clk = ~clk;

  bolme_denetleyici dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .istek_gecerli_i(ig),
    .istek_hazir_o(ih),
    .istek_islem_i(iop),
    .istek_bolunen_i(ia),
    .istek_bolen_i(ib),
    .istek_hedef_i(itag),
    .iptal_i(iptal),
    .sonuc_gecerli_o(sg),
    .sonuc_hazir_i(sh),
    .sonuc_o(sonuc),
    .sonuc_hedef_o(stag),
    .bolme_baslat_o(baslat),
    .bolme_islem_o(bop),
    .bolme_bolunen_o(ba),
    .bolme_bolen_o(bb),
    .bolme_sonuc_i(bsonuc),
    .bolme_bitti_i(bbitti),
    .mesgul_sayac_o(sayac)
  );

  // Divider model: counts while start is high, clears when it drops
  logic [4:0] dcnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dcnt <= '0;
    else if (!baslat) dcnt <= '0;
    else if (dcnt != 5'(DIV_LAT - 1)) dcnt <= dcnt + 5'd1;
  end
  assign bbitti = !baslat || (dcnt == 5'(DIV_LAT - 1));

  function automatic logic [31:0] bol(logic [1:0] op,
                                      logic [31:0] a,
                                      logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV:  bol = (b == 0) ? 32'hFFFF_FFFF : ovf ? a
                   : $unsigned($signed(a) / $signed(b));
      OP_REM:  bol = (b == 0) ? a : ovf ? 32'd0
                   : $unsigned($signed(a) % $signed(b));
      OP_DIVU: bol = (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: bol = (b == 0) ? a : a % b;
    endcase
  endfunction
  assign bsonuc = bol(bop, ba, bb);

  task automatic chk(input string ad, input logic [63:0] gozlenen,
                     input logic [63:0] beklenen);
    tests++;
    assert (gozlenen === beklenen) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", ad, gozlenen, beklenen);
    end
  endtask

  // Drive a request once ready, return #1 after the accept edge
  task automatic gonder(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] bek, input bit kaydet);
    int n;
    bek_t e;
    n = 0;
    @(negedge clk);
    while (!ih && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ih) chk("accept_timeout", 64'(ih), 64'd1);
    ig = 1'b1; iop = op; ia = a; ib = b; itag = tag;
    @(posedge clk);
    #1 ig = 1'b0;
    if (kaydet) begin
      e.tag = tag;
      e.val = bek;
      sb.push_back(e);
    end
  endtask

  task automatic bekle(output int lat);
    lat = 0;
    while (!sg && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!sg) chk("result_timeout", 64'(sg), 64'd1);
  endtask

  task automatic karsilastir(input string ad);
    bek_t e;
    if (sb.size() == 0) begin
      chk({ad, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({ad, "_val"}, 64'(sonuc), 64'(e.val));
      chk({ad, "_tag"}, 64'(stag), 64'(e.tag));
    end
  endtask

  task automatic el_sikis;
    sh = 1'b1;
    @(posedge clk);
    #1 sh = 1'b0;
  endtask

  initial begin
    int lat;
    int gordu;
    logic [31:0] s0;

    // Reset state
    #12;
    chk("rst_hazir", 64'(ih), 64'd0);
    chk("rst_gecerli", 64'(sg), 64'd0);
    chk("rst_baslat", 64'(baslat), 64'd0);
    chk("rst_sayac", 64'(sayac), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("idle_hazir", 64'(ih), 64'd1);

    // DIV -7/2 with latency and busy count
    gonder(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 1);
    chk("div_baslat", 64'(baslat), 64'd1);
    bekle(lat);
    chk("div_lat", 64'(lat), 64'(EXP_LAT));
    karsilastir("div_m7_2");
    chk("div_sayac", 64'(sayac), 64'(DIV_LAT));
    chk("div_done_baslat", 64'(baslat), 64'd0);
    el_sikis();

    gonder(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 1);
    bekle(lat);
    karsilastir("rem_m7_2");
    el_sikis();
    gonder(OP_DIVU, 32'd100, 32'd0, 5'd7, 32'hFFFF_FFFF, 1);
    bekle(lat);
    karsilastir("divu_by0");
    el_sikis();
    gonder(OP_REMU, 32'd100, 32'd0, 5'd8, 32'd100, 1);
    bekle(lat);
    karsilastir("remu_by0");
    el_sikis();

    // Writeback stall with a request pending behind it
    gonder(OP_DIV, 32'd20, 32'd4, 5'd9, 32'd5, 1);
    bekle(lat);
    ig = 1'b1; iop = OP_DIVU; ia = 32'd10; ib = 32'd3; itag = 5'd10;
    for (int i = 0; i < 10; i++) begin
      chk("stall_sonuc", 64'(sonuc), 64'd5);
      chk("stall_hazir", 64'({ih, baslat, sg}), 64'b001);
      @(posedge clk);
      #1;
    end
    karsilastir("stall_div");
    sh = 1'b1;
    #1 chk("b2b_hazir", 64'(ih), 64'd1);
    @(posedge clk);
    #1 sh = 1'b0; ig = 1'b0;
    begin
      bek_t e;
      e.tag = 5'd10;
      e.val = 32'd3;
      sb.push_back(e);
    end
    chk("b2b_state", 64'({baslat, sg}), 64'b10);
    bekle(lat);
    chk("b2b_lat", 64'(lat), 64'(EXP_LAT));
    karsilastir("b2b_divu");
    el_sikis();

    // Flush on cycle 8 of HESAPLA
    gonder(OP_DIV, 32'd50, 32'd5, 5'd11, 32'd0, 0);
    repeat (7) @(posedge clk);
    #1 iptal = 1'b1;
    @(posedge clk);
    #1 iptal = 1'b0;
    chk("iptal_state", 64'({baslat, ih}), 64'b01);
    gordu = 0;
    repeat (30) begin
      @(posedge clk);
      #1 if (sg) gordu++;
    end
    chk("iptal_no_result", 64'(gordu), 64'd0);
    s0 = sayac;
    gonder(OP_DIVU, 32'd10, 32'd3, 5'd12, 32'd3, 1);
    bekle(lat);
    chk("post_iptal_lat", 64'(lat), 64'(EXP_LAT));
    chk("post_iptal_sayac", 64'(sayac - s0), 64'(DIV_LAT));
    karsilastir("post_iptal");
    el_sikis();

    // Flush in idle blocks a concurrent request
    @(negedge clk);
    ig = 1'b1; iptal = 1'b1; iop = OP_DIV; ia = 32'd9; ib = 32'd3;
    @(posedge clk);
    #1 ig = 1'b0; iptal = 1'b0;
    chk("iptal_idle", 64'({baslat, ih}), 64'b01);

    // Flush discards a waiting result
    gonder(OP_DIV, 32'd8, 32'd2, 5'd14, 32'd0, 0);
    bekle(lat);
    iptal = 1'b1;
    #1 chk("iptal_sonuc_hazir", 64'(ih), 64'd0);
    @(posedge clk);
    #1 iptal = 1'b0;
    chk("iptal_sonuc", 64'({sg, ih}), 64'b01);

    // Asynchronous reset mid-operation
    gonder(OP_DIV, 32'd40, 32'd4, 5'd15, 32'd0, 0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("amid_ctl", 64'({ih, sg, baslat, bop, stag}), 64'd0);
    chk("amid_data", {ba, bb}, 64'd0);
    chk("amid_sonuc", {sonuc, sayac}, 64'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    gonder(OP_DIV, 32'd6, 32'd3, 5'd13, 32'd2, 1);
    bekle(lat);
    chk("post_rst_lat", 64'(lat), 64'(EXP_LAT));
    chk("post_rst_sayac", 64'(sayac), 64'(DIV_LAT));
    karsilastir("post_rst");
    el_sikis();

`ifdef BOLME_ONBELLEK_EN
    s0 = sayac;
    gonder(OP_DIVU, 32'd50, 32'd7, 5'd1, 32'd7, 1);
    bekle(lat);
    chk("onb_miss_lat", 64'(lat), 64'(EXP_LAT));
    karsilastir("onb_miss");
    el_sikis();
    chk("onb_miss_sayac", 64'(sayac - s0), 64'(DIV_LAT));
    s0 = sayac;
    gonder(OP_DIVU, 32'd50, 32'd7, 5'd2, 32'd7, 1);
    chk("onb_hit_baslat", 64'(baslat), 64'd0);
    bekle(lat);
    chk("onb_hit_lat", 64'(lat), 64'd0);
    karsilastir("onb_hit");
    el_sikis();
    chk("onb_hit_sayac", 64'(sayac), 64'(s0));
`endif

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
